// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for a 256x32 synchronous-read instruction memory.
// Owns the PC, tracks the one-cycle read latency and buffers returned words
// in a two-entry FIFO that feeds decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;

  // Fetch stage: program counter presented to the memory.
  logic [ADDR_W-1:0] pc_q;

  // Read stage: a request is outstanding at the memory; its data arrives this cycle.
  logic              vld_p1;
  logic [ADDR_W-1:0] req_pc_p1;

  // Output FIFO: entry 0 is the head shown to decode, entry 1 the tail.
  logic [1:0]        count_q;
  logic [DATA_W-1:0] dat0_q, dat1_q;
  logic [ADDR_W-1:0] pc0_q, pc1_q;

  logic              pop;
  logic              push;
  logic              redirect;
  logic              issue;
  logic [2:0]        occ;
  logic [2:0]        occ_lim;
  logic [1:0]        slot;

  assign inst_valid = (count_q != 2'd0);
  assign inst       = dat0_q;
  assign inst_pc    = pc0_q;
  assign imem_addr  = pc_q;
  assign busy       = (state_q != S_IDLE) || (count_q != 2'd0) || vld_p1;

  assign pop      = inst_valid & inst_ready;
  // A redirect only flushes while the sequencer is active; in IDLE it just moves the PC.
  assign redirect = branch_valid && (state_q != S_IDLE);
  // The returning word is dropped when a redirect lands in the same cycle.
  assign push     = vld_p1 && !redirect;
  // Credit check: buffered + in-flight entries must leave room, counting a same-cycle pop as freed.
  assign occ      = {1'b0, count_q} + {2'b00, vld_p1};
  assign occ_lim  = 3'd2 + {2'b00, pop};
  assign issue    = (state_q == S_RUN) && (occ < occ_lim) && !branch_valid && !stop;
  // FIFO position the incoming word lands in after this cycle's pop.
  assign slot     = count_q - {1'b0, pop};

  // Control state machine: IDLE -> RUN on start, RUN -> DRAIN on stop, DRAIN -> IDLE once empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= S_RUN;
        S_RUN:   if (stop) state_q <= S_DRAIN;
        S_DRAIN: if ((count_q == 2'd0) && !vld_p1) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // PC update and read-latency tracking; a branch always wins over sequential fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (branch_valid) begin
        pc_q <= branch_target;
      end else if (issue) begin
        pc_q <= pc_q + 1'b1;
      end
    end
  end

  // PC tag of the outstanding read; only consumed while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= pc_q;
  end

  // FIFO occupancy and head entry; head is cleared on reset so inst/inst_pc read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      dat0_q  <= '0;
      pc0_q   <= '0;
    end else if (redirect) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        dat0_q <= dat1_q;
        pc0_q  <= pc1_q;
      end
      if (push && (slot == 2'd0)) begin
        dat0_q <= imem_rdata;
        pc0_q  <= req_pc_p1;
      end
    end
  end

  // FIFO tail entry; written only when the head is already occupied after this cycle's pop.
  always_ff @(posedge clk) begin
    if (push && !redirect && (slot == 2'd1)) begin
      dat1_q <= imem_rdata;
      pc1_q  <= req_pc_p1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a synchronous-read memory model
// preloaded so that mem[a] = a + 1.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_ready = 1'b0;
  logic        busy;

  logic [31:0] mem [256];
  int          errors = 0;
  int          checks = 0;

  fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    stop = 1'b0;
    branch_valid = 1'b0;
    inst_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] wrap_pc [4];
    wrap_pc[0] = 8'd254;
    wrap_pc[1] = 8'd255;
    wrap_pc[2] = 8'd0;
    wrap_pc[3] = 8'd1;
    for (int i = 0; i < 256; i++) mem[i] = i + 1;

    // Asynchronous reset state, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", imem_addr, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: streaming from reset, first valid two edges after start.
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_valid_e0", inst_valid, 0);
    tick();
    check("t1_valid_e1", inst_valid, 0);
    check("t1_addr_e1", imem_addr, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", inst_valid, 1);
      check("t1_inst", inst, k + 1);
      check("t1_pc", inst_pc, k);
      tick();
    end

    // Test 2: stall with head pc=2 held, then resume without gaps.
    do_reset();
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t2_head_inst", inst, 3);
    check("t2_head_pc", inst_pc, 2);
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_inst", inst, 3);
      check("t2_hold_pc", inst_pc, 2);
      check("t2_hold_addr", imem_addr, 4);
    end
    inst_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      tick();
      check("t2_resume_valid", inst_valid, 1);
      check("t2_resume_inst", inst, k + 1);
      check("t2_resume_pc", inst_pc, k);
    end

    // Test 3: branch to 6 while pc=3 is in flight.
    do_reset();
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t3_pre_pc", inst_pc, 2);
    check("t3_pre_addr", imem_addr, 4);
    branch_target = 8'd6;
    branch_valid = 1'b1;
    tick();
    branch_valid = 1'b0;
    check("t3_flush_valid", inst_valid, 0);
    check("t3_addr", imem_addr, 6);
    tick();
    check("t3_gap_valid", inst_valid, 0);
    tick();
    check("t3_first_valid", inst_valid, 1);
    check("t3_first_inst", inst, 7);
    check("t3_first_pc", inst_pc, 6);
    tick();
    check("t3_next_inst", inst, 8);
    check("t3_next_pc", inst_pc, 7);

    // Test 4: PC wrap after branching to 254.
    branch_target = 8'd254;
    branch_valid = 1'b1;
    tick();
    branch_valid = 1'b0;
    check("t4_flush_valid", inst_valid, 0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t4_valid", inst_valid, 1);
      check("t4_pc", inst_pc, wrap_pc[k]);
      check("t4_inst", inst, 32'(wrap_pc[k]) + 32'd1);
      tick();
    end

    // Test 5: stop with two entries buffered, then drain to IDLE.
    do_reset();
    inst_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t5_full_inst", inst, 1);
    check("t5_full_pc", inst_pc, 0);
    check("t5_full_addr", imem_addr, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_drain_busy", busy, 1);
    check("t5_drain_pc", inst_pc, 0);
    check("t5_drain_addr", imem_addr, 2);
    inst_ready = 1'b1;
    tick();
    check("t5_second_valid", inst_valid, 1);
    check("t5_second_inst", inst, 2);
    check("t5_second_pc", inst_pc, 1);
    tick();
    check("t5_empty_valid", inst_valid, 0);
    tick();
    check("t5_idle_busy", busy, 0);
    check("t5_idle_addr", imem_addr, 2);
    check("t5_idle_valid", inst_valid, 0);
    branch_target = 8'd10;
    branch_valid = 1'b1;
    tick();
    branch_valid = 1'b0;
    check("t5_idle_br_addr", imem_addr, 10);
    check("t5_idle_br_busy", busy, 0);
    tick();
    check("t5_idle_br_hold", imem_addr, 10);

    // Test 6: asynchronous reset mid-stream, then restart from RESET_PC.
    do_reset();
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t6_pre_valid", inst_valid, 1);
    check("t6_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", inst_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_inst", inst, 0);
    check("t6_async_pc", inst_pc, 0);
    check("t6_async_addr", imem_addr, 0);
    #1 rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t6_restart_valid", inst_valid, 1);
    check("t6_restart_pc", inst_pc, 0);
    check("t6_restart_inst", inst, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
